// File: rtl/pb_ram_arbiter.sv
// rtl/pb_ram_arbiter.sv - two-requester arbiter/sequencer for one shared single-port block RAM
// Round-robin by default; define PB_ARB_FIXED_PRIO_EN for fixed r0 priority on ties.
module pb_ram_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_valid,
  input  logic          r0_we,
  input  logic          r0_lock,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ready,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_valid,
  input  logic          r1_we,
  input  logic          r1_lock,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ready,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, WR, RD1, RD2} state_t;

  state_t state, state_next;

  logic          lock_active;
  logic          lock_owner;
  logic          gnt;
  logic          sel0, sel1;
  logic          accept;
  logic          acc_id;
  logic          acc_we;
  logic          acc_lock;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;

`ifndef PB_ARB_FIXED_PRIO_EN
  logic          last_grant;
`endif

  // A locked owner excludes the other side entirely; otherwise ties are broken here.
  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    if (lock_active) begin
      sel0 = ~lock_owner;
      sel1 = lock_owner;
    end else if (r0_valid && r1_valid) begin
`ifdef PB_ARB_FIXED_PRIO_EN
      sel0 = 1'b1;
`else
      sel0 = last_grant;
      sel1 = ~last_grant;
`endif
    end else begin
      sel0 = 1'b1;
      sel1 = 1'b1;
    end
  end

  assign r0_ready  = (state == IDLE) & ~reset & r0_valid & sel0;
  assign r1_ready  = (state == IDLE) & ~reset & r1_valid & sel1;
  assign accept    = r0_ready | r1_ready;
  assign acc_id    = r1_ready;
  assign acc_we    = acc_id ? r1_we    : r0_we;
  assign acc_lock  = acc_id ? r1_lock  : r0_lock;
  assign acc_addr  = acc_id ? r1_addr  : r0_addr;
  assign acc_wdata = acc_id ? r1_wdata : r0_wdata;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = acc_we ? WR : RD1;
      WR:      state_next = IDLE;
      RD1:     state_next = RD2;
      RD2:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // RAM strobes are launched from the accept so they land in WR/RD1 and self-clear after.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_active <= 1'b0;
      lock_owner  <= 1'b0;
      gnt         <= 1'b0;
`ifndef PB_ARB_FIXED_PRIO_EN
      last_grant  <= 1'b1;
`endif
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_din     <= '0;
      r0_rvalid   <= 1'b0;
      r1_rvalid   <= 1'b0;
      r0_rdata    <= '0;
      r1_rdata    <= '0;
    end else begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      if (accept) begin
        gnt         <= acc_id;
`ifndef PB_ARB_FIXED_PRIO_EN
        last_grant  <= acc_id;
`endif
        lock_active <= acc_lock;
        lock_owner  <= acc_id;
        ram_en      <= 1'b1;
        ram_we      <= acc_we;
        ram_addr    <= acc_addr;
        ram_din     <= acc_we ? acc_wdata : '0;
      end
      if (state == RD2) begin
        if (gnt) begin
          r1_rdata  <= ram_dout;
          r1_rvalid <= 1'b1;
        end else begin
          r0_rdata  <= ram_dout;
          r0_rvalid <= 1'b1;
        end
      end
    end
  end

endmodule
